wifi_tx_ofdm_frame_sequencer: RTL and testbench

WIFI_TX_OFDM_FRAME_SEQUENCER -- requirements
Module: WIFI_TX_ofdm_frame_sequencer

---
 rtl/wifi_tx_ofdm_frame_sequencer.sv | 129 ++++++++++++
 tb/tb_wifi_tx_ofdm_frame_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wifi_tx_ofdm_frame_sequencer.sv
// Sequences one OFDM frame: forwards preamble samples, kicks the IFFT, then
// forwards fixed-length symbols until the symbol flagged last completes.
module wifi_tx_ofdm_frame_sequencer #(
    parameter int DATA_W  = 12,
    parameter int SYM_LEN = 80,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pre_valid,
    input  logic [DATA_W-1:0] pre_re,
    input  logic [DATA_W-1:0] pre_im,
    input  logic              pre_done,
    input  logic              sym_valid,
    input  logic [DATA_W-1:0] sym_re,
    input  logic [DATA_W-1:0] sym_im,
    input  logic              last_sym,
    input  logic              irq_en,
    input  logic              irq_clear,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              ifft_start,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  sym_count,
    output logic              err,
    output logic              irq,
    output logic [2:0]        dbg_state
);

    localparam int SAMP_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam logic [SAMP_W-1:0] LAST_SAMP = SAMP_W'(SYM_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE      = 3'd1,
        WAIT_SYM = 3'd2,
        DATA     = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SAMP_W-1:0] samp_cnt;
    logic              last_latch;
    logic              done_flag;

    logic pre_fwd;
    logic sym_acc;
    logic sym_end;
    logic last_seen;
    logic violation;

    // Streams have no backpressure: a sample is taken in the cycle its valid is
    // high in an accepting state, and out_valid marks each forwarded sample
    // exactly one cycle later.
    always_comb begin
        state_nxt = state;
        pre_fwd   = (state == PRE) && pre_valid;
        sym_acc   = sym_valid && ((state == WAIT_SYM) || (state == DATA));
        sym_end   = sym_acc && (samp_cnt == LAST_SAMP);
        last_seen = last_latch || (sym_acc && last_sym);
        violation = (sym_valid && ((state == IDLE) || (state == PRE)))
                  || (pre_valid && ((state == WAIT_SYM) || (state == DATA) || (state == DONE)))
                  || (pre_done && (state != PRE));
        case (state)
            IDLE:     if (start) state_nxt = PRE;
            PRE:      if (pre_done) state_nxt = WAIT_SYM;
            WAIT_SYM,
            DATA: begin
                if (sym_end)      state_nxt = last_seen ? DONE : WAIT_SYM;
                else if (sym_acc) state_nxt = DATA;
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            last_latch <= 1'b0;
            sym_count  <= '0;
            out_valid  <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
            ifft_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            out_valid  <= pre_fwd || sym_acc;
            out_re     <= pre_fwd ? pre_re : (sym_acc ? sym_re : '0);
            out_im     <= pre_fwd ? pre_im : (sym_acc ? sym_im : '0);
            ifft_start <= (state == PRE) && pre_done;

            if (sym_end)      samp_cnt <= '0;
            else if (sym_acc) samp_cnt <= samp_cnt + 1'b1;

            if (sym_end)                  last_latch <= 1'b0;
            else if (sym_acc && last_sym) last_latch <= 1'b1;

            if ((state == IDLE) && start)              sym_count <= '0;
            else if (sym_end && (sym_count != CNT_MAX)) sym_count <= sym_count + 1'b1;
        end
    end

    // A clear in the same cycle as a set wins, so software never loses a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_flag <= 1'b0;
            err       <= 1'b0;
        end else if (irq_clear) begin
            done_flag <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (state == DONE) done_flag <= 1'b1;
            if (violation)     err       <= 1'b1;
        end
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign irq        = (done_flag || err) && irq_en;
    assign dbg_state  = state;

endmodule

// File: tb/tb_wifi_tx_ofdm_frame_sequencer.sv
// Directed bench for the frame sequencer: a driver pushes each sample it expects
// forwarded, tagged with its due cycle; a negedge monitor pops and compares.
module tb_wifi_tx_ofdm_frame_sequencer;

    localparam int DATA_W = 12;
    localparam int EXP_W  = 16 + 2 * DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, pre_valid, pre_done, sym_valid, last_sym, irq_en, irq_clear;
    logic [DATA_W-1:0] pre_re, pre_im, sym_re, sym_im;

    logic              out_valid, ifft_start, busy, frame_done, err, irq;
    logic [DATA_W-1:0] out_re, out_im;
    logic [7:0]        sym_count;
    logic [2:0]        dbg_state;

    logic              s_out_valid, s_ifft_start, s_busy, s_frame_done, s_err, s_irq;
    logic [DATA_W-1:0] s_out_re, s_out_im;
    logic [1:0]        s_sym_count;
    logic [2:0]        s_dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_cnt = 0;
    int ifft_cnt = 0;
    int done_cnt = 0;
    int s_done_cnt = 0;

    wifi_tx_ofdm_frame_sequencer #(.DATA_W(DATA_W), .SYM_LEN(80), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pre_valid(pre_valid),
        .pre_re(pre_re), .pre_im(pre_im), .pre_done(pre_done), .sym_valid(sym_valid),
        .sym_re(sym_re), .sym_im(sym_im), .last_sym(last_sym), .irq_en(irq_en),
        .irq_clear(irq_clear), .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .ifft_start(ifft_start), .busy(busy), .frame_done(frame_done),
        .sym_count(sym_count), .err(err), .irq(irq), .dbg_state(dbg_state)
    );

    // Same stimulus, narrow symbol counter for the saturation case.
    wifi_tx_ofdm_frame_sequencer #(.DATA_W(DATA_W), .SYM_LEN(80), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .start(start), .pre_valid(pre_valid),
        .pre_re(pre_re), .pre_im(pre_im), .pre_done(pre_done), .sym_valid(sym_valid),
        .sym_re(sym_re), .sym_im(sym_im), .last_sym(last_sym), .irq_en(irq_en),
        .irq_clear(irq_clear), .out_valid(s_out_valid), .out_re(s_out_re), .out_im(s_out_im),
        .ifft_start(s_ifft_start), .busy(s_busy), .frame_done(s_frame_done),
        .sym_count(s_sym_count), .err(s_err), .irq(s_irq), .dbg_state(s_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] got;
        if (ifft_start) ifft_cnt++;
        if (frame_done) done_cnt++;
        if (s_frame_done) s_done_cnt++;
        if (out_valid) begin
            out_cnt++;
            checks++;
            got = {16'(cyc), out_re, out_im};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got cyc=%0d re=%h im=%h required nothing", cyc, out_re, out_im);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL out_sample got cyc=%0d re=%h im=%h required cyc=%0d re=%h im=%h",
                             cyc, out_re, out_im, e[EXP_W-1 -: 16], e[2*DATA_W-1 -: DATA_W], e[DATA_W-1:0]);
                end
            end
        end else begin
            checks++;
            if (out_re !== '0 || out_im !== '0) begin
                errors++;
                $display("FAIL out_idle_zero got re=%h im=%h required 0", out_re, out_im);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] pre_re_f(input int i);
        return DATA_W'(i * 3 + 1);
    endfunction
    function automatic logic [DATA_W-1:0] pre_im_f(input int i);
        return DATA_W'(2048 - i);
    endfunction
    function automatic logic [DATA_W-1:0] sym_re_f(input int s, input int i);
        return DATA_W'(s * 256 + i);
    endfunction
    function automatic logic [DATA_W-1:0] sym_im_f(input int s, input int i);
        return ~DATA_W'(s * 256 + i + 7);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        start = 0; pre_valid = 0; pre_re = '0; pre_im = '0; pre_done = 0;
        sym_valid = 0; sym_re = '0; sym_im = '0; last_sym = 0; irq_clear = 0;
    endtask

    task automatic push(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
        exp_q.push_back({16'(cyc + 1), re, im});
    endtask

    task automatic do_start();
        start = 1; tick(); clr();
    endtask

    task automatic do_irq_clear();
        irq_clear = 1; tick(); clr();
    endtask

    task automatic pre_sample(input int i, input bit done);
        pre_valid = 1; pre_re = pre_re_f(i); pre_im = pre_im_f(i); pre_done = done;
        push(pre_re, pre_im);
        tick(); clr();
    endtask

    task automatic pulse_pre_done();
        pre_done = 1; tick(); clr();
    endtask

    task automatic run_pre(input int n);
        for (int i = 0; i < n; i++) pre_sample(i, 1'b0);
        pulse_pre_done();
    endtask

    task automatic sym_sample(input int s, input int i, input bit last, input bit st);
        sym_valid = 1; sym_re = sym_re_f(s, i); sym_im = sym_im_f(s, i);
        last_sym = last; start = st;
        push(sym_re, sym_im);
        tick(); clr();
    endtask

    task automatic run_syms(input int nsym, input int last_at);
        for (int s = 0; s < nsym; s++)
            for (int i = 0; i < 80; i++)
                sym_sample(s, i, (s == nsym - 1) && (i == last_at), 1'b0);
    endtask

    task automatic wait_done(input string name, input int target);
        for (int k = 0; k < 20 && done_cnt < target; k++) tick();
        check(name, done_cnt, target);
    endtask

    task automatic reset_counts();
        out_cnt = 0; ifft_cnt = 0; done_cnt = 0; s_done_cnt = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 0; irq_en = 0; clr();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sym_count", sym_count, 0);
        check("rst_err_irq", {err, irq, ifft_start, frame_done}, 0);
        check("rst_state", dbg_state, 0);
        reset = 1;
        tick();

        // Nominal frame: 160 preamble, 3 symbols, last flagged mid symbol 3.
        irq_en = 1; reset_counts();
        do_start();
        check("start_busy", busy, 1);
        run_pre(160);
        run_syms(3, 10);
        wait_done("nom_frame_done", 1);
        tick();
        check("nom_ifft_start", ifft_cnt, 1);
        check("nom_out_count", out_cnt, 400);
        check("nom_sym_count", sym_count, 3);
        check("nom_irq", irq, 1);
        check("nom_idle", busy, 0);
        check("nom_queue_empty", exp_q.size(), 0);
        do_irq_clear();
        check("nom_irq_cleared", irq, 0);

        // Gapped single last symbol, preamble ends with sample+done together.
        irq_en = 0; reset_counts();
        do_start();
        for (int i = 0; i < 4; i++) pre_sample(i, i == 3);
        for (int i = 0; i < 80; i++) begin
            sym_sample(0, i, 1'b1, 1'b0);
            if (i < 79) begin
                sym_re = 12'h777; sym_im = 12'h333; last_sym = 1;
                tick(); clr();
            end
        end
        wait_done("gap_frame_done", 1);
        tick();
        check("gap_out_count", out_cnt, 84);
        check("gap_sym_count", sym_count, 1);
        check("gap_ifft_start", ifft_cnt, 1);
        check("gap_irq_masked", irq, 0);
        irq_en = 1;
        #1;
        check("gap_irq_unmasked", irq, 1);
        do_irq_clear();
        check("gap_irq_cleared", irq, 0);

        // Violations, ignored start in DATA, clear racing frame_done.
        reset_counts();
        pulse_pre_done();
        check("vio_pre_done_err", err, 1);
        check("vio_pre_done_state", dbg_state, 0);
        do_irq_clear();
        do_start();
        for (int i = 0; i < 4; i++) pre_sample(i, 1'b0);
        sym_valid = 1; sym_re = 12'h5A5; sym_im = 12'hA5A;
        tick(); clr();
        check("vio_sym_err", err, 1);
        check("vio_sym_irq", irq, 1);
        check("vio_sym_state", dbg_state, 1);
        pre_sample(4, 1'b0);
        do_irq_clear();
        check("vio_clear_err", err, 0);
        check("vio_clear_irq", irq, 0);
        pulse_pre_done();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 80; i++)
                sym_sample(s, i, (s == 1) && (i == 79), (s == 1) && (i == 20));
        check("vio_in_done", dbg_state, 4);
        check("vio_start_ignored", sym_count, 2);
        do_irq_clear();
        tick();
        check("race_frame_done", done_cnt, 1);
        check("race_irq", irq, 0);
        check("race_out_count", out_cnt, 165);

        // Reset at sample 40 of symbol 2.
        reset_counts();
        do_start();
        run_pre(8);
        for (int i = 0; i < 80; i++) sym_sample(0, i, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) sym_sample(1, i, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 0;
        #1;
        check("mid_rst_out", {out_valid, out_re, out_im}, 0);
        check("mid_rst_flags", {busy, ifft_start, frame_done, err, irq}, 0);
        check("mid_rst_sym_count", sym_count, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1;
        tick();
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_queue", exp_q.size(), 0);
        do_start();
        run_pre(8);
        run_syms(2, 79);
        wait_done("rerun_frame_done", 1);
        check("rerun_sym_count", sym_count, 2);

        // Five symbols: narrow counter saturates, wide one counts on.
        reset_counts();
        do_start();
        run_pre(8);
        run_syms(5, 0);
        wait_done("sat_frame_done", 1);
        tick();
        check("sat_narrow_done", s_done_cnt, 1);
        check("sat_narrow_count", s_sym_count, 3);
        check("sat_wide_count", sym_count, 5);
        check("sat_out_count", out_cnt, 408);
        check("sat_narrow_idle", {s_busy, s_err}, 0);
        check("sat_queue_empty", exp_q.size(), 0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
